multi_digit_scan_drv: RTL and testbench

Parametrised successor to the fixed 4-digit, 16-bit multiplexed 7-segment driver. It scans NUM_DIGITS common-drain digits from a hex data word, one digit at a time. New over the 4-digit driver:
- programmable scan rate via an internal prescaler, so no derived clock is needed;
- PWM brightness with a blank dead-time phase for anti-ghosting;
- per-digit decimal points;
- leading-zero suppression;
- tear-free, frame-synchronous data update.
It sits between user logic (counters, LFSR, CPU port) and the board's digit drains and segment pins.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/decode_8seg.sv | 11 +
 rtl/multi_digit_scan_drv.sv | 170 +++++++++++++++++
 tb/tb_multi_digit_scan_drv.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit positions, blank pattern and hex glyph table.
// Segment order is {dp,g,f,e,d,c,b,a}, active high.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/decode_8seg.sv
// Combinational hex nibble to segments a..g decoder, zero latency, no flow control.
module decode_8seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/multi_digit_scan_drv.sv
// Multiplexed N-digit 7-segment scanner with prescaled PWM, dead-time blanking, LZ suppression.
// Outputs are registered; data is double-buffered and swapped only at frame boundaries.
module multi_digit_scan_drv
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1024,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Oe,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic [NUM_DIGITS-1:0]   i_Dp,
    input  logic                    i_Data_Valid,
    input  logic                    i_Lz_En,
    input  logic [BRIGHT_BITS-1:0]  i_Bright,
    output logic [NUM_DIGITS-1:0]   o_Drains,
    output logic [7:0]              o_Leds,
    output logic                    o_Frame_Start
);

    localparam int PW     = $clog2(PRESCALE);
    localparam int DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]          PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BRIGHT_BITS-1:0] PHASE_MAX = '1;
    localparam logic [DW-1:0]          DIGIT_MAX = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [BRIGHT_BITS-1:0] phase_q, phase_d;
    logic [DW-1:0]          digit_q, digit_d;
    logic [DATA_W-1:0]      pend_dat_q, pend_dat_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]      shd_dat_q, shd_dat_d;
    logic [NUM_DIGITS-1:0]  shd_dp_q, shd_dp_d;
    logic                   oe_q;
    logic [NUM_DIGITS-1:0]  drains_q, drains_d;
    logic [7:0]             leds_q, leds_d;
    logic                   fs_q, fs_d;

    logic       tick;
    logic       boundary;
    logic       load_shadow;
    logic [3:0] sel_nib;
    logic       sel_dp;
    logic       sel_blank;
    logic       zero_run;
    logic       drive_on;
    logic [6:0] dec_seg;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            presc_q    <= '0;
            phase_q    <= '0;
            digit_q    <= '0;
            pend_dat_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            shd_dat_q  <= '0;
            shd_dp_q   <= '0;
            oe_q       <= 1'b0;
            drains_q   <= '0;
            leds_q     <= SEG_BLANK;
            fs_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            digit_q    <= digit_d;
            pend_dat_q <= pend_dat_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            shd_dat_q  <= shd_dat_d;
            shd_dp_q   <= shd_dp_d;
            oe_q       <= i_Oe;
            drains_q   <= drains_d;
            leds_q     <= leds_d;
            fs_q       <= fs_d;
        end
    end

    // Scan counters and the pending -> shadow transfer at frame boundary or OE rise.
    always_comb begin
        presc_d     = presc_q;
        phase_d     = phase_q;
        digit_d     = digit_q;
        pend_dat_d  = pend_dat_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        shd_dat_d   = shd_dat_q;
        shd_dp_d    = shd_dp_q;
        boundary    = 1'b0;
        tick        = (presc_q == PRESC_MAX);

        if (!i_Oe) begin
            presc_d = '0;
            phase_d = '0;
            digit_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                phase_d = phase_q + 1'b1;
                if (phase_q == PHASE_MAX) begin
                    if (digit_q == DIGIT_MAX) begin
                        digit_d  = '0;
                        boundary = 1'b1;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end
            end
        end

        load_shadow = i_Oe && (boundary || !oe_q);
        if (load_shadow && pend_vld_q) begin
            shd_dat_d  = pend_dat_q;
            shd_dp_d   = pend_dp_q;
            pend_vld_d = 1'b0;
        end

        // A strobe coinciding with the swap lands in pending for the following frame.
        if (i_Data_Valid) begin
            pend_dat_d = i_Data;
            pend_dp_d  = i_Dp;
            pend_vld_d = 1'b1;
        end
    end

    // Digit select and leading-zero run, evaluated on the post-edge state.
    always_comb begin
        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (shd_dat_d[4*k +: 4] == 4'h0);
            if (digit_d == DW'(k)) begin
                sel_nib   = shd_dat_d[4*k +: 4];
                sel_dp    = shd_dp_d[k];
                sel_blank = i_Lz_En && zero_run && (k != 0);
            end
        end
    end

    decode_8seg u_decode (
        .nibble_i (sel_nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        drains_d = '0;
        leds_d   = SEG_BLANK;
        drive_on = i_Oe && (phase_d != '0) && (phase_d <= i_Bright);
        if (drive_on) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                drains_d[k] = (digit_d == DW'(k));
            end
            leds_d[SEG_DP]        = sel_dp;
            leds_d[SEG_G:SEG_A]   = sel_blank ? 7'h00 : dec_seg;
        end
        fs_d = boundary;
    end

    assign o_Drains      = drains_q;
    assign o_Leds        = leds_q;
    assign o_Frame_Start = fs_q;

endmodule

// File: tb/tb_multi_digit_scan_drv.sv
// Directed bench: a 4-digit and a 3-digit scanner, PRESCALE=4, BRIGHT_BITS=2.
module tb_multi_digit_scan_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oe;
    logic        lz;
    logic [1:0]  bright;

    logic [15:0] data_a;
    logic [3:0]  dp_a;
    logic        vld_a;
    logic [3:0]  drains_a;
    logic [7:0]  leds_a;
    logic        fs_a;

    logic [11:0] data_b;
    logic [2:0]  dp_b;
    logic        vld_b;
    logic [2:0]  drains_b;
    logic [7:0]  leds_b;
    logic        fs_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] cap_dr [64];
    logic [7:0] cap_ld [64];
    logic       cap_fs [64];

    always #5 clk = ~clk;

    multi_digit_scan_drv #(.NUM_DIGITS(4), .PRESCALE(4), .BRIGHT_BITS(2)) u_dut_a (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Oe          (oe),
        .i_Data        (data_a),
        .i_Dp          (dp_a),
        .i_Data_Valid  (vld_a),
        .i_Lz_En       (lz),
        .i_Bright      (bright),
        .o_Drains      (drains_a),
        .o_Leds        (leds_a),
        .o_Frame_Start (fs_a)
    );

    multi_digit_scan_drv #(.NUM_DIGITS(3), .PRESCALE(4), .BRIGHT_BITS(2)) u_dut_b (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Oe          (oe),
        .i_Data        (data_b),
        .i_Dp          (dp_b),
        .i_Data_Valid  (vld_b),
        .i_Lz_En       (lz),
        .i_Bright      (bright),
        .o_Drains      (drains_b),
        .o_Leds        (leds_b),
        .o_Frame_Start (fs_b)
    );

    // Slot = 16 clocks: 4 clocks per phase, phase 0 dark, phases 1..bright lit.
    function automatic logic [3:0] exp_dr_f(input int s, input int b);
        int slot = s / 16;
        int ph   = (s % 16) / 4;
        return (ph != 0 && ph <= b) ? 4'(1 << slot) : 4'h0;
    endfunction

    function automatic logic [7:0] exp_ld_f(input int s, input int b, input logic [31:0] e);
        int slot = s / 16;
        int ph   = (s % 16) / 4;
        return (ph != 0 && ph <= b) ? e[8*slot +: 8] : 8'h00;
    endfunction

    function automatic int slot_mismatch(input int k, input int b, input logic [31:0] e);
        int bad = 0;
        for (int s = 16 * k; s < 16 * k + 16; s++) begin
            if (cap_dr[s] !== exp_dr_f(s, b) || cap_ld[s] !== exp_ld_f(s, b, e)) bad++;
        end
        return bad;
    endfunction

    function automatic int slot_on(input int k);
        int n = 0;
        for (int s = 16 * k; s < 16 * k + 16; s++) begin
            if (cap_dr[s] != 4'h0) n++;
        end
        return n;
    endfunction

    task automatic strobe_a(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        data_a = d;
        dp_a   = p;
        vld_a  = 1'b1;
        @(negedge clk);
        vld_a  = 1'b0;
    endtask

    task automatic wait_fs_a(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fs_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no frame start within 300 clocks (fs=%b, want 1)", name, fs_a);
        end
    endtask

    task automatic capture_a();
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            cap_dr[s] = drains_a;
            cap_ld[s] = leds_a;
            cap_fs[s] = fs_a;
        end
    endtask

    task automatic test_reset();
        int nfs = 0;
        rst_n = 1'b0; oe = 1'b1; lz = 1'b0; bright = 2'd3;
        data_a = '0; dp_a = '0; vld_a = 1'b0;
        data_b = '0; dp_b = '0; vld_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (drains_a !== 4'h0 || leds_a !== 8'h00 || fs_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: drains=%b leds=%h fs=%b, want 0000 00 0", drains_a, leds_a, fs_a);
        end
        checks++;
        if (drains_b !== 3'h0 || leds_b !== 8'h00 || fs_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: drains=%b leds=%h fs=%b, want 000 00 0", drains_b, leds_b, fs_b);
        end
        rst_n = 1'b1;
        capture_a();
        for (int s = 0; s < 64; s++) if (cap_fs[s]) nfs++;
        checks++;
        if (nfs != 0) begin
            errors++;
            $display("FAIL first_frame_fs: pulses=%0d, want 0", nfs);
        end
        checks++;
        if (cap_dr[3] !== 4'h0 || cap_dr[4] !== 4'b0001 || cap_ld[4] !== 8'h3F) begin
            errors++;
            $display("FAIL first_digit0: dr3=%b dr4=%b ld4=%h, want 0000 0001 3f", cap_dr[3], cap_dr[4], cap_ld[4]);
        end
        checks++;
        if (cap_dr[20] !== 4'b0010 || cap_ld[20] !== 8'h3F) begin
            errors++;
            $display("FAIL first_digit1: dr=%b ld=%h, want 0010 3f", cap_dr[20], cap_ld[20]);
        end
    endtask

    task automatic test_count();
        int bad, on, nfs;
        strobe_a(16'h1234, 4'h0);
        wait_fs_a("count_wait");
        capture_a();
        for (int k = 0; k < 4; k++) begin
            bad = slot_mismatch(k, 3, 32'h065B4F66);
            on  = slot_on(k);
            checks++;
            if (bad != 0 || on != 12) begin
                errors++;
                $display("FAIL count_slot%0d: mismatches=%0d lit=%0d, want 0 and 12", k, bad, on);
            end
        end
        nfs = 0;
        for (int s = 1; s < 64; s++) if (cap_fs[s]) nfs++;
        checks++;
        if (cap_fs[0] !== 1'b1 || nfs != 0) begin
            errors++;
            $display("FAIL count_fs: fs0=%b extra=%0d, want 1 and 0", cap_fs[0], nfs);
        end
    endtask

    task automatic test_pwm();
        int bad;
        bright = 2'd1;
        wait_fs_a("pwm1_wait");
        capture_a();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (slot_mismatch(k, 1, 32'h065B4F66) != 0 || slot_on(k) != 4) begin
                errors++;
                $display("FAIL pwm1_slot%0d: lit=%0d, want 4", k, slot_on(k));
            end
        end
        bright = 2'd0;
        wait_fs_a("pwm0_wait");
        capture_a();
        bad = 0;
        for (int k = 0; k < 4; k++) bad += slot_mismatch(k, 0, 32'h065B4F66);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pwm0_dark: non-dark samples=%0d, want 0", bad);
        end
    endtask

    task automatic test_tear();
        int bad, n77;
        bright = 2'd3;
        wait_fs_a("tear_wait");
        for (int s = 0; s < 64; s++) begin
            if (s > 0) @(negedge clk);
            cap_dr[s] = drains_a;
            cap_ld[s] = leds_a;
            cap_fs[s] = fs_a;
            if (s == 20) begin data_a = 16'hAAAA; vld_a = 1'b1; end
            if (s == 21) vld_a = 1'b0;
            if (s == 40) begin data_a = 16'h5555; vld_a = 1'b1; end
            if (s == 41) vld_a = 1'b0;
        end
        bad = 0;
        n77 = 0;
        for (int k = 0; k < 4; k++) bad += slot_mismatch(k, 3, 32'h065B4F66);
        for (int s = 0; s < 64; s++) if (cap_ld[s] == 8'h77) n77++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tear_old_frame: mismatches=%0d, want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (fs_a !== 1'b1) begin
            errors++;
            $display("FAIL tear_boundary: fs=%b, want 1", fs_a);
        end
        capture_a();
        bad = 0;
        for (int k = 0; k < 4; k++) bad += slot_mismatch(k, 3, 32'h6D6D6D6D);
        for (int s = 0; s < 64; s++) if (cap_ld[s] == 8'h77) n77++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tear_new_frame: mismatches=%0d, want 0", bad);
        end
        checks++;
        if (n77 != 0) begin
            errors++;
            $display("FAIL tear_no_aaaa: samples showing 77=%0d, want 0", n77);
        end
    endtask

    task automatic test_lz();
        int bad;
        lz = 1'b1;
        strobe_a(16'h0040, 4'h0);
        wait_fs_a("lz_wait");
        capture_a();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (slot_mismatch(k, 3, 32'h0000663F) != 0 || slot_on(k) != 12) begin
                errors++;
                $display("FAIL lz0040_slot%0d: mismatches=%0d lit=%0d, want 0 and 12",
                         k, slot_mismatch(k, 3, 32'h0000663F), slot_on(k));
            end
        end
        strobe_a(16'h0000, 4'h0);
        wait_fs_a("lz0_wait");
        capture_a();
        bad = 0;
        for (int k = 0; k < 4; k++) bad += slot_mismatch(k, 3, 32'h0000003F);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lz0000: mismatches=%0d, want 0", bad);
        end
        lz = 1'b0;
    endtask

    task automatic test_dp_odd();
        logic [2:0] bdr [49];
        logic [7:0] bld [49];
        logic       bfs [49];
        bit ok = 1'b0;
        int bad = 0;
        int nfs = 0;
        @(negedge clk);
        data_b = 12'h888; dp_b = 3'b010; vld_b = 1'b1;
        @(negedge clk);
        vld_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fs_b === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL odd_wait: no frame start within 300 clocks (fs=%b, want 1)", fs_b);
        end
        for (int s = 0; s < 49; s++) begin
            if (s > 0) @(negedge clk);
            bdr[s] = drains_b;
            bld[s] = leds_b;
            bfs[s] = fs_b;
        end
        for (int s = 0; s < 48; s++) begin
            if (bdr[s] !== 3'(exp_dr_f(s, 3)) || bld[s] !== exp_ld_f(s, 3, 32'h007FFF7F)) bad++;
            if (bfs[s]) nfs++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL odd_scan: mismatches=%0d, want 0", bad);
        end
        checks++;
        if (nfs != 1 || bfs[0] !== 1'b1 || bfs[48] !== 1'b1) begin
            errors++;
            $display("FAIL odd_fs: pulses=%0d fs0=%b fs48=%b, want 1 1 1", nfs, bfs[0], bfs[48]);
        end
        checks++;
        if (bdr[20] !== 3'b010 || bld[20] !== 8'hFF || bdr[36] !== 3'b100 || bld[36] !== 8'h7F) begin
            errors++;
            $display("FAIL odd_dp: d1=%b/%h d2=%b/%h, want 010/ff 100/7f", bdr[20], bld[20], bdr[36], bld[36]);
        end
    endtask

    task automatic test_async_oe();
        bit ok = 1'b0;
        int nz = 0;
        int first = -1;
        logic [3:0] fdr = 4'h0;
        logic [7:0] fld = 8'h00;
        bright = 2'd3;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (drains_a != 4'h0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL async_wait: drains=%b, want nonzero within 100 clocks", drains_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (drains_a !== 4'h0 || leds_a !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: drains=%b leds=%h, want 0000 00", drains_a, leds_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin data_a = 16'h0007; dp_a = 4'h0; vld_a = 1'b1; end
            if (i == 2) vld_a = 1'b0;
            @(negedge clk);
            if (drains_a != 4'h0 || leds_a != 8'h00 || fs_a != 1'b0) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL oe_low: nonzero samples=%0d, want 0", nz);
        end
        oe = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            if (first < 0 && drains_a != 4'h0) begin
                first = s;
                fdr = drains_a;
                fld = leds_a;
            end
        end
        checks++;
        if (first != 4 || fdr !== 4'b0001 || fld !== 8'h07) begin
            errors++;
            $display("FAIL oe_restart: first lit at %0d drains=%b leds=%h, want 4 0001 07", first, fdr, fld);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pwm();
        test_tear();
        test_lz();
        test_dp_odd();
        test_async_oe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
